gray_pointer_rx: RTL and testbench

GRAY_POINTER_RX -- requirements
Module: gray_pointer_rx

---
 rtl/gray_pkg.sv | 13 +
 rtl/gray_code.sv | 22 ++
 rtl/gray_pointer_rx.sv | 145 ++++++++++++++
 tb/tb_gray_pointer_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared FSM state type and default sizing for the Gray pointer receiver
package gray_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_PRIME  = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_WIDTH       = 4;

endpackage

// File: rtl/gray_code.sv
// rtl/gray_code.sv - combinational Gray/binary converter; INVERT=1 decodes Gray to binary
module gray_code #(
    parameter int WIDTH  = 4,
    parameter bit INVERT = 1'b0
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (INVERT) begin : g_decode
        // Each binary bit is the XOR of all Gray bits at and above it.
        always_comb begin
            dout = '0;
            for (int i = 0; i < WIDTH; i++) begin
                dout[i] = ^(din >> i);
            end
        end
    end else begin : g_encode
        assign dout = din ^ (din >> 1);
    end

endmodule

// File: rtl/gray_pointer_rx.sv
// rtl/gray_pointer_rx.sv - synchronize, decode and track a foreign-domain Gray pointer
// Define GRAY_POINTER_RX_ERROR_CHECK_EN to flag multi-bit Gray changes as errors.
module gray_pointer_rx
    import gray_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clear_error,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] advance,
    output logic             valid_step,
    output logic             error,
    output logic             locked
);

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] WARM_LAST = CW'(SYNC_STAGES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] gray_sync;
    logic [WIDTH-1:0] bin_sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] binary_q;
    logic [WIDTH-1:0] advance_q;
    logic             valid_q;
    logic             error_q;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] delta;
    logic             moved;
    logic             single;
    logic             step_ok;
    logic             illegal;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign gray_sync = sync_q[SYNC_STAGES-1];

    gray_code #(
        .WIDTH  (WIDTH),
        .INVERT (1'b1)
    ) u_decode (
        .din  (gray_sync),
        .dout (bin_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // WARMUP lasts exactly as long as the sync chain takes to fill with live data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = ST_PRIME;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PRIME: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_WARMUP;
        endcase
    end

    assign diff   = gray_sync ^ prev_q;
    assign moved  = |diff;
    assign single = moved && ((diff & (diff - WIDTH'(1))) == '0);
    assign delta  = bin_sync - binary_q;

`ifdef GRAY_POINTER_RX_ERROR_CHECK_EN
    assign step_ok = single;
    assign illegal = moved && !single;
`else
    assign step_ok = moved;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            binary_q  <= '0;
            prev_q    <= '0;
            advance_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_PRIME: begin
                    binary_q  <= bin_sync;
                    prev_q    <= gray_sync;
                    advance_q <= '0;
                end
                ST_RUN: begin
                    valid_q <= step_ok;
                    if (moved) begin
                        binary_q  <= bin_sync;
                        prev_q    <= gray_sync;
                        advance_q <= delta;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new violation outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (state_q == ST_RUN && illegal) begin
            error_q <= 1'b1;
        end else if (clear_error) begin
            error_q <= 1'b0;
        end
    end

    assign binary_out = binary_q;
    assign advance    = advance_q;
    assign valid_step = valid_q;
    assign error      = error_q;
    assign locked     = (state_q == ST_RUN);

endmodule

// File: tb/tb_gray_pointer_rx.sv
// tb/tb_gray_pointer_rx.sv - self-checking bench for gray_pointer_rx (WIDTH=4, SYNC_STAGES=2)
module tb_gray_pointer_rx;

`ifdef GRAY_POINTER_RX_ERROR_CHECK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
        logic [3:0] adv;
        logic       vs;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] adv;
        int         due;
    } sb_t;

    logic       clk;
    logic       reset;
    logic [3:0] gray_in;
    logic       clear_error;
    logic [3:0] binary_out;
    logic [3:0] advance;
    logic       valid_step;
    logic       error;
    logic       locked;

    int   tests;
    int   fails;
    int   cyc;
    int   pulses;
    sb_t  sb[$];
    vec_t walk[18];

    gray_pointer_rx #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gray_in     (gray_in),
        .clear_error (clear_error),
        .binary_out  (binary_out),
        .advance     (advance),
        .valid_step  (valid_step),
        .error       (error),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic vec_t mkvec(input logic [3:0] b, input logic [3:0] adv);
        vec_t v;
        v.gray = to_gray(b);
        v.bin  = b;
        v.adv  = adv;
        v.vs   = 1'b1;
        v.err  = 1'b0;
        return v;
    endfunction

    // Scoreboard monitor: each expected step must pulse exactly on its due cycle.
    always @(posedge clk) begin
        #1;
        if (valid_step === 1'b1) pulses++;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check("sb_valid_step", int'(valid_step), 1);
            check("sb_binary_out", int'(binary_out), int'(sb[0].bin));
            check("sb_advance", int'(advance), int'(sb[0].adv));
            void'(sb.pop_front());
        end else if (valid_step !== 1'b0) begin
            check("spurious_valid_step", int'(valid_step), 0);
        end
    end

    task automatic apply(input vec_t v, input string tag);
        gray_in = v.gray;
        if (v.vs) sb.push_back('{v.bin, v.adv, cyc + 3});
        repeat (3) tick();
        check({tag, "_bin"}, int'(binary_out), int'(v.bin));
        check({tag, "_adv"}, int'(advance), int'(v.adv));
        check({tag, "_vs"}, int'(valid_step), int'(v.vs));
        check({tag, "_err"}, int'(error), int'(v.err));
        tick();
        check({tag, "_vs_drop"}, int'(valid_step), 0);
    endtask

    initial begin
        int start_pulses;
        tests = 0;
        fails = 0;
        cyc = 0;
        pulses = 0;
        reset = 1'b1;
        gray_in = 4'b0000;
        clear_error = 1'b0;

        // Pre-step to binary 15 (wrap backwards), then walk 0..15 and back to 0.
        walk[0] = mkvec(4'd15, 4'd15);
        for (int j = 1; j < 18; j++) walk[j] = mkvec(4'((j - 1) % 16), 4'd1);

        tick();
        check("rst_bin", int'(binary_out), 0);
        check("rst_adv", int'(advance), 0);
        check("rst_vs", int'(valid_step), 0);
        check("rst_err", int'(error), 0);
        check("rst_locked", int'(locked), 0);
        reset = 1'b0;

        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("warm%0d_locked", k), int'(locked), (k == 3) ? 1 : 0);
            check($sformatf("warm%0d_bin", k), int'(binary_out), 0);
            check($sformatf("warm%0d_err", k), int'(error), 0);
        end
        repeat (2) tick();

        apply(walk[0], "prestep");
        start_pulses = pulses;
        for (int j = 1; j < 18; j++) apply(walk[j], $sformatf("walk%0d", j));
        check("walk_pulses", pulses - start_pulses, 17);

        // Two-bit jump 0000 -> 0011.
        gray_in = 4'b0011;
        if (!ERRCHK) sb.push_back('{4'd2, 4'd2, cyc + 3});
        repeat (3) tick();
        check("jump_bin", int'(binary_out), 2);
        check("jump_adv", int'(advance), 2);
        check("jump_vs", int'(valid_step), ERRCHK ? 0 : 1);
        check("jump_err", int'(error), ERRCHK ? 1 : 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("hold%0d_err", k), int'(error), ERRCHK ? 1 : 0);
            check($sformatf("hold%0d_bin", k), int'(binary_out), 2);
        end
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("clear_err", int'(error), 0);

        apply(mkvec(4'd1, 4'd15), "back1");

        // Clear and violation land on the same edge: set must win.
        gray_in = 4'b0110;
        if (!ERRCHK) sb.push_back('{4'd4, 4'd3, cyc + 3});
        repeat (2) tick();
        check("race_pre_err", int'(error), 0);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("race_err", int'(error), ERRCHK ? 1 : 0);
        check("race_bin", int'(binary_out), 4);
        check("race_adv", int'(advance), 3);
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check("race_clear", int'(error), 0);

        for (int b = 5; b <= 9; b++) apply(mkvec(4'(b), 4'd1), $sformatf("up%0d", b));

        // Mid-run reset with gray 1101 held: re-prime silently to 9.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_bin", int'(binary_out), 0);
        check("mid_rst_adv", int'(advance), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_err", int'(error), 0);
        repeat (2) tick();
        check("reprime_locked_early", int'(locked), 0);
        check("reprime_bin_early", int'(binary_out), 0);
        tick();
        check("reprime_locked", int'(locked), 1);
        check("reprime_bin", int'(binary_out), 9);
        check("reprime_adv", int'(advance), 0);
        check("reprime_vs", int'(valid_step), 0);
        check("reprime_err", int'(error), 0);
        repeat (4) tick();
        check("final_bin", int'(binary_out), 9);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
